// File: rtl/shifter_pkg.sv
// Shared op encodings and legality check for the pipelined shifter.
package shifter_pkg;
  localparam logic [2:0] SHIFT_SLL  = 3'b000;
  localparam logic [2:0] SHIFT_SRL  = 3'b001;
  localparam logic [2:0] SHIFT_SRA  = 3'b010;
  localparam logic [2:0] SHIFT_ROTL = 3'b011;
  localparam logic [2:0] SHIFT_ROTR = 3'b100;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= SHIFT_ROTR;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// Combinational slice applying mux levels HI down to LO; illegal ops pass data through.
// No latency or backpressure of its own; the enclosing pipeline registers the result.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO = 0,
  parameter int HI = 0,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [2:0]         i_op,
  input  logic               i_sign,
  output logic [WIDTH-1:0]   o_data
);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic w_unused_shamt;
  assign w_unused_shamt = &{1'b0, i_shamt};

  always_comb begin
    o_data = i_data;
    if (is_legal_op(i_op)) begin
      for (int k = HI; k >= LO; k--) begin
        if (i_shamt[k]) begin
          case (i_op)
            SHIFT_SLL:  o_data = o_data << (1 << k);
            SHIFT_SRL:  o_data = o_data >> (1 << k);
            // the fill bit is the operand MSB captured at entry, not the current MSB
            SHIFT_SRA:  o_data = (o_data >> (1 << k)) | (i_sign ? ~(ONES >> (1 << k)) : '0);
            SHIFT_ROTL: o_data = (o_data << (1 << k)) | (o_data >> (WIDTH - (1 << k)));
            SHIFT_ROTR: o_data = (o_data >> (1 << k)) | (o_data << (WIDTH - (1 << k)));
            default:    o_data = i_data;
          endcase
        end
      end
    end
  end
endmodule

// File: rtl/pipelined_shifter.sv
// Log-depth shift/rotate split into LATENCY registered stages; result LATENCY-1 edges after accept.
// Elastic valid/ready with bubble collapse; in_ready is combinational from out_ready, forced low on flush.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int LATENCY = (SHAMT_W + REG_EVERY - 1) / REG_EVERY
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);
  logic [WIDTH-1:0]   r_data  [LATENCY];
  logic [SHAMT_W-1:0] r_shamt [LATENCY];
  logic [2:0]         r_op    [LATENCY];
  logic [TAG_W-1:0]   r_tag   [LATENCY];
  logic [LATENCY-1:0] r_v, r_sign;

  logic [WIDTH-1:0]   w_src_data  [LATENCY];
  logic [WIDTH-1:0]   w_res_data  [LATENCY];
  logic [SHAMT_W-1:0] w_src_shamt [LATENCY];
  logic [2:0]         w_src_op    [LATENCY];
  logic [TAG_W-1:0]   w_src_tag   [LATENCY];
  logic [LATENCY-1:0] w_src_v, w_src_sign, w_ld;
  logic               w_chain;
  logic               w_unused_tail;

  // w_ld[s]: stage s register may capture this cycle (empty, or its content moves on)
  always_comb begin
    w_ld = '0;
    w_chain = ~r_v[LATENCY-1] | out_ready;
    for (int s = LATENCY - 1; s >= 0; s--) begin
      w_ld[s] = ~r_v[s] | w_chain;
      w_chain = w_ld[s];
    end
  end

  assign in_ready = w_ld[0] & ~flush;

  always_comb begin
    w_src_v        = '0;
    w_src_sign     = '0;
    w_src_v[0]     = in_valid & in_ready;
    w_src_data[0]  = in_data;
    w_src_shamt[0] = in_shamt;
    w_src_op[0]    = in_op;
    w_src_tag[0]   = in_tag;
    w_src_sign[0]  = in_data[WIDTH-1];
    for (int s = 1; s < LATENCY; s++) begin
      w_src_v[s]     = r_v[s-1];
      w_src_data[s]  = r_data[s-1];
      w_src_shamt[s] = r_shamt[s-1];
      w_src_op[s]    = r_op[s-1];
      w_src_tag[s]   = r_tag[s-1];
      w_src_sign[s]  = r_sign[s-1];
    end
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int HI = SHAMT_W - 1 - s * REG_EVERY;
    localparam int LO = (HI - REG_EVERY + 1 < 0) ? 0 : HI - REG_EVERY + 1;
    shift_stage #(.WIDTH(WIDTH), .LO(LO), .HI(HI)) u_stage (
      .i_data  (w_src_data[s]),
      .i_shamt (w_src_shamt[s]),
      .i_op    (w_src_op[s]),
      .i_sign  (w_src_sign[s]),
      .o_data  (w_res_data[s])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v    <= '0;
      r_sign <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_op[s]    <= SHIFT_SLL;
        r_tag[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        if (w_ld[s]) begin
          r_v[s]     <= w_src_v[s];
          r_data[s]  <= w_res_data[s];
          r_shamt[s] <= w_src_shamt[s];
          r_op[s]    <= w_src_op[s];
          r_tag[s]   <= w_src_tag[s];
          r_sign[s]  <= w_src_sign[s];
        end
      end
      if (flush) r_v <= '0;
    end
  end

  assign out_valid   = r_v[LATENCY-1];
  assign out_data    = r_data[LATENCY-1];
  assign out_tag     = r_tag[LATENCY-1];
  assign out_illegal = ~is_legal_op(r_op[LATENCY-1]);

  assign w_unused_tail = &{1'b0, r_sign[LATENCY-1], r_shamt[LATENCY-1]};
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench: directed table, back-pressure, flush and reset sequences, random traffic vs model.
module tb_pipelined_shifter;
  localparam int LATENCY = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_illegal;

  always #5 clock = ~clock;

  pipelined_shifter #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ill;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  sh;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp_d;
    logic        exp_ill;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[14];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_tag;
  logic [31:0] cur_exp_data = '0;
  logic        cur_exp_ill = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      3'd0: return d << sh;
      3'd1: return d >> sh;
      3'd2: return 32'($signed(d) >>> sh);
      3'd3: begin dd = dd << sh; return dd[63:32]; end
      3'd4: begin dd = dd >> sh; return dd[31:0]; end
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op, input logic [4:0] tag);
    in_valid = 1'b1;
    in_data = d;
    in_shamt = sh;
    in_op = op;
    in_tag = tag;
    cur_exp_data = model(d, sh, op);
    cur_exp_ill = (op > 3'd4);
  endtask

  // One cycle: sample mid-cycle at negedge (scoreboard), then advance to just after the next posedge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clock);
    acc = 1'b0;
    if (!reset_n) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          check("out_illegal", out_illegal, e.ill);
          if (chk_lat) check("latency", cyc - e.acc_cyc, LATENCY);
        end
      end
      held = out_valid && !out_ready && !flush;
      held_data = out_data;
      held_tag = out_tag;
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sb.push_back('{cur_exp_data, in_tag, cur_exp_ill, cyc});
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  initial begin
    bit acc;
    int accepted;
    int c;

    tbl[0]  = '{32'h0000_0001, 5'd31, 3'b000, 5'd7,  32'h8000_0000, 1'b0};
    tbl[1]  = '{32'h8000_0010, 5'd4,  3'b010, 5'd8,  32'hF800_0001, 1'b0};
    tbl[2]  = '{32'h8000_0010, 5'd4,  3'b001, 5'd9,  32'h0800_0001, 1'b0};
    tbl[3]  = '{32'h8000_0001, 5'd1,  3'b011, 5'd10, 32'h0000_0003, 1'b0};
    tbl[4]  = '{32'h8000_0001, 5'd1,  3'b100, 5'd11, 32'hC000_0000, 1'b0};
    tbl[5]  = '{32'hDEAD_BEEF, 5'd0,  3'b000, 5'd12, 32'hDEAD_BEEF, 1'b0};
    tbl[6]  = '{32'hDEAD_BEEF, 5'd0,  3'b010, 5'd13, 32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{32'h1234_5678, 5'd3,  3'b110, 5'd14, 32'h1234_5678, 1'b1};
    tbl[8]  = '{32'h1234_5678, 5'd4,  3'b000, 5'd15, 32'h2345_6780, 1'b0};
    tbl[9]  = '{32'hCAFE_0001, 5'd9,  3'b101, 5'd16, 32'hCAFE_0001, 1'b1};
    tbl[10] = '{32'h7FFF_FFFF, 5'd31, 3'b010, 5'd17, 32'h0000_0000, 1'b0};
    tbl[11] = '{32'h8000_0000, 5'd31, 3'b010, 5'd18, 32'hFFFF_FFFF, 1'b0};
    tbl[12] = '{32'h1234_5678, 5'd16, 3'b011, 5'd19, 32'h5678_1234, 1'b0};
    tbl[13] = '{32'h1234_5678, 5'd8,  3'b100, 5'd20, 32'h7812_3456, 1'b0};

    // Asynchronous reset from time zero
    #2 reset_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_out_illegal", out_illegal, 0);
    idle(3);
    reset_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Directed table, back-to-back with the consumer always ready
    out_ready = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].d, tbl[i].sh, tbl[i].op, tbl[i].tag);
      cur_exp_data = tbl[i].exp_d;
      cur_exp_ill = tbl[i].exp_ill;
      tick(acc);
      check("table_accept", acc, 1);
    end
    idle(LATENCY + 2);
    check("table_drained", sb.size(), 0);

    // Back-pressure: six ops against a consumer stalled for six cycles
    chk_lat = 1'b0;
    accepted = 0;
    c = 0;
    while ((accepted < 6 || sb.size() != 0) && c < 40) begin
      out_ready = (c >= 6);
      if (accepted < 6) drive($urandom(), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 5'(accepted + 1));
      else in_valid = 1'b0;
      #1;
      if (c == 4) check("bp_in_ready_low", in_ready, 0);
      if (c == 4) check("bp_accepts_before_stall", accepted, 3);
      tick(acc);
      if (acc) accepted++;
      c++;
    end
    check("bp_all_accepted", accepted, 6);
    check("bp_all_emerged", sb.size(), 0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive($urandom(), 5'($urandom()), 3'($urandom()), 5'($urandom()));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      tick(acc);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(LATENCY + 2);
    check("random_drained", sb.size(), 0);

    // Flush with three ops in flight: none may emerge
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_00F0 + i, 5'd2, 3'b000, 5'(21 + i));
      tick(acc);
      check("flush_fill_accept", acc, 1);
    end
    check("flush_pre_valid", out_valid, 1);
    drive(32'h5555_5555, 5'd1, 3'b001, 5'd30);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      check("flush_stays_empty", out_valid, 0);
    end

    // Reset with ops in flight, then a cold operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom(), 5'($urandom()), 3'b011, 5'(i + 1));
      tick(acc);
    end
    in_valid = 1'b0;
    check("prereset_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_data", out_data, 0);
    check("async_reset_tag", out_tag, 0);
    idle(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    chk_lat = 1'b1;
    drive(32'h0000_0001, 5'd31, 3'b000, 5'd7);
    tick(acc);
    check("cold_accept", acc, 1);
    idle(LATENCY + 2);
    check("cold_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
